instruction_fetch: RTL and testbench

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

---
 rtl/cpu_pkg.sv | 42 ++++
 rtl/instruction_fetch.sv | 112 +++++++++++
 tb/tb_instruction_fetch.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode values, fetch FSM encoding, assembled
// instruction record, and the opcode-to-length decode used by the fetch unit.
package cpu_pkg;

    localparam logic [7:0] OP_NOP    = 8'h00;
    localparam logic [7:0] OP_ADD    = 8'h01;
    localparam logic [7:0] OP_SUB    = 8'h02;
    localparam logic [7:0] OP_MOV_RR = 8'h03;
    localparam logic [7:0] OP_MOV_RA = 8'h04;
    localparam logic [7:0] OP_MOV_AR = 8'h05;
    localparam logic [7:0] OP_MOV_IR = 8'h06;
    localparam logic [7:0] OP_JMP    = 8'h07;
    localparam logic [7:0] OP_JNB    = 8'h09;
    localparam logic [7:0] OP_CLR    = 8'h12;

    typedef enum logic [1:0] {
        FETCH_OP,
        FETCH_B1,
        FETCH_B2,
        HOLD
    } fetch_state_e;

    typedef struct packed {
        logic [7:0] opcode;
        logic [7:0] op1;
        logic [7:0] op2;
        logic [1:0] len;
        logic [7:0] pc;
    } instr_t;

    // Unknown opcodes are treated as single-byte so the fetcher never stalls on them.
    function automatic logic [1:0] instr_length(input logic [7:0] opcode);
        logic [1:0] len;
        case (opcode)
            OP_ADD, OP_SUB, OP_MOV_RR, OP_JMP:       len = 2'd2;
            OP_MOV_RA, OP_MOV_AR, OP_MOV_IR, OP_JNB: len = 2'd3;
            default:                                 len = 2'd1;
        endcase
        return len;
    endfunction

endpackage

// File: rtl/instruction_fetch.sv
// Byte-serial instruction fetch: reads one program byte per cycle, assembles
// 1..3 byte instructions and presents them on a valid/ready handshake.
module instruction_fetch
    import cpu_pkg::*;
#(
    parameter logic [7:0] RESET_PC = 8'h00
) (
    input  logic       clk,
    input  logic       rst,
    output logic [7:0] pm_addr,
    input  logic [7:0] pm_data,
    input  logic       jump_en,
    input  logic [7:0] jump_addr,
    output logic       instr_valid,
    input  logic       instr_ready,
    output logic [7:0] instr_opcode,
    output logic [7:0] instr_op1,
    output logic [7:0] instr_op2,
    output logic [1:0] instr_len,
    output logic [7:0] instr_pc
);

    localparam instr_t INSTR_RESET = '{opcode: 8'h00, op1: 8'h00, op2: 8'h00,
                                       len: 2'd1, pc: 8'h00};

    logic [7:0]   pc_q, pc_d;
    fetch_state_e state_q, state_d;
    instr_t       instr_q, instr_d;
    logic         valid_q, valid_d;
    logic [1:0]   fetch_len;
    logic         take_opcode;

    assign fetch_len = instr_length(pm_data);

    // NOTE: every signal written here gets a default first so no path leaves it
    // unassigned; a missing default would infer a latch.
    always_comb begin
        pc_d        = pc_q;
        state_d     = state_q;
        instr_d     = instr_q;
        valid_d     = valid_q;
        take_opcode = 1'b0;

        if (jump_en) begin
            // A redirect discards anything partially assembled or still held.
            pc_d    = jump_addr;
            state_d = FETCH_OP;
            valid_d = 1'b0;
        end else begin
            case (state_q)
                FETCH_OP: take_opcode = 1'b1;
                FETCH_B1: begin
                    instr_d.op1 = pm_data;
                    pc_d        = pc_q + 8'd1;
                    if (instr_q.len == 2'd2) begin
                        state_d = HOLD;
                        valid_d = 1'b1;
                    end else begin
                        state_d = FETCH_B2;
                    end
                end
                FETCH_B2: begin
                    instr_d.op2 = pm_data;
                    pc_d        = pc_q + 8'd1;
                    state_d     = HOLD;
                    valid_d     = 1'b1;
                end
                HOLD:     take_opcode = instr_ready;
                default:  state_d = FETCH_OP;
            endcase
        end

        // Shared by FETCH_OP and an accepted HOLD, so back-to-back transfers lose no cycle.
        if (take_opcode) begin
            instr_d = '{opcode: pm_data, op1: 8'h00, op2: 8'h00,
                        len: fetch_len, pc: pc_q};
            pc_d    = pc_q + 8'd1;
            if (fetch_len == 2'd1) begin
                state_d = HOLD;
                valid_d = 1'b1;
            end else begin
                state_d = FETCH_B1;
                valid_d = 1'b0;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q    <= RESET_PC;
            state_q <= FETCH_OP;
            instr_q <= INSTR_RESET;
            valid_q <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            state_q <= state_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
        end
    end

    assign pm_addr      = pc_q;
    assign instr_valid  = valid_q;
    assign instr_opcode = instr_q.opcode;
    assign instr_op1    = instr_q.op1;
    assign instr_op2    = instr_q.op2;
    assign instr_len    = instr_q.len;
    assign instr_pc     = instr_q.pc;

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: directed vector table, corner
// sequences, and randomized traffic against a byte-queue reference model.
module tb_instruction_fetch;

    logic       clk;
    logic       rst;
    logic [7:0] pm_addr;
    logic [7:0] pm_data;
    logic       jump_en;
    logic [7:0] jump_addr;
    logic       instr_valid;
    logic       instr_ready;
    logic [7:0] instr_opcode;
    logic [7:0] instr_op1;
    logic [7:0] instr_op2;
    logic [1:0] instr_len;
    logic [7:0] instr_pc;

    logic [7:0] mem [256];

    int checks = 0;
    int errors = 0;

    instruction_fetch #(.RESET_PC(8'h00)) dut (
        .clk         (clk),
        .rst         (rst),
        .pm_addr     (pm_addr),
        .pm_data     (pm_data),
        .jump_en     (jump_en),
        .jump_addr   (jump_addr),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr_opcode(instr_opcode),
        .instr_op1   (instr_op1),
        .instr_op2   (instr_op2),
        .instr_len   (instr_len),
        .instr_pc    (instr_pc)
    );

    assign pm_data = mem[pm_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: current fetch address, bytes gathered so far, held instruction.
    logic [7:0] m_pc;
    logic [7:0] m_bytes[$];
    logic       m_valid;
    logic [7:0] m_op, m_op1, m_op2, m_ipc;
    int         m_len;

    function automatic int ref_len(input logic [7:0] op);
        case (op)
            8'h01, 8'h02, 8'h03, 8'h07: return 2;
            8'h04, 8'h05, 8'h06, 8'h09: return 3;
            default:                    return 1;
        endcase
    endfunction

    task automatic model_edge(input logic r, input logic j, input logic [7:0] ja,
                              input logic rd);
        if (r) begin
            m_pc = 8'h00;
            m_bytes.delete();
            m_valid = 1'b0;
        end else if (j) begin
            m_pc = ja;
            m_bytes.delete();
            m_valid = 1'b0;
        end else if (!m_valid || rd) begin
            m_valid = 1'b0;
            m_bytes.push_back(mem[m_pc]);
            m_pc = m_pc + 8'd1;
            if (m_bytes.size() == ref_len(m_bytes[0])) begin
                m_len   = m_bytes.size();
                m_op    = m_bytes[0];
                m_op1   = (m_len > 1) ? m_bytes[1] : 8'h00;
                m_op2   = (m_len > 2) ? m_bytes[2] : 8'h00;
                m_ipc   = m_pc - 8'(m_len);
                m_valid = 1'b1;
                m_bytes.delete();
            end
        end
    endtask

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Drive inputs, advance one clock, update the model, sample 1 time unit later.
    task automatic step(input logic r, input logic j, input logic [7:0] ja,
                        input logic rd);
        rst         = r;
        jump_en     = j;
        jump_addr   = ja;
        instr_ready = rd;
        @(posedge clk);
        model_edge(r, j, ja, rd);
        #1;
    endtask

    task automatic check_instr(input string tag, input logic [7:0] op,
                               input logic [7:0] o1, input logic [7:0] o2,
                               input logic [1:0] len, input logic [7:0] pc);
        check({tag, ".opcode"}, instr_opcode, op);
        check({tag, ".op1"},    instr_op1,    o1);
        check({tag, ".op2"},    instr_op2,    o2);
        check({tag, ".len"},    instr_len,    len);
        check({tag, ".pc"},     instr_pc,     pc);
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    endtask

    typedef struct {
        logic       rst;
        logic       jmp;
        logic [7:0] ja;
        logic       rdy;
        logic       ev;
        logic [7:0] epm;
        logic [7:0] eop;
        logic [7:0] eop1;
        logic [7:0] eop2;
        logic [1:0] elen;
        logic [7:0] epc;
    } vec_t;

    vec_t vecs[13];
    logic [7:0] op_pool[10] = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04,
                                8'h05, 8'h06, 8'h07, 8'h09, 8'h12};

    initial begin
        rst = 1'b1; jump_en = 1'b0; jump_addr = 8'h00; instr_ready = 1'b0;
        m_pc = 8'h00; m_valid = 1'b0; m_op = 8'h00; m_op1 = 8'h00;
        m_op2 = 8'h00; m_ipc = 8'h00; m_len = 1;

        // 3-byte fetch, backpressure, 1- and 2-byte follow-ups, jump from HOLD.
        clear_mem();
        mem[0] = 8'h05; mem[1] = 8'h07; mem[2] = 8'h02;
        mem[3] = 8'h12; mem[4] = 8'h01; mem[5] = 8'h33;
        vecs[0]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 2'd1, 8'h00};
        vecs[1]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h01, 8'h00, 8'h00, 8'h00, 2'd1, 8'h00};
        vecs[2]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h02, 8'h00, 8'h00, 8'h00, 2'd1, 8'h00};
        vecs[3]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h03, 8'h05, 8'h07, 8'h02, 2'd3, 8'h00};
        for (int i = 4; i < 8; i++) vecs[i] = vecs[3];
        vecs[8]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h04, 8'h12, 8'h00, 8'h00, 2'd1, 8'h03};
        vecs[9]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h05, 8'h00, 8'h00, 8'h00, 2'd1, 8'h00};
        vecs[10] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h06, 8'h01, 8'h33, 8'h00, 2'd2, 8'h04};
        vecs[11] = '{1'b0, 1'b1, 8'h10, 1'b1, 1'b0, 8'h10, 8'h00, 8'h00, 8'h00, 2'd1, 8'h00};
        vecs[12] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h11, 8'h00, 8'h00, 8'h00, 2'd1, 8'h10};

        for (int i = 0; i < 13; i++) begin
            step(vecs[i].rst, vecs[i].jmp, vecs[i].ja, vecs[i].rdy);
            check($sformatf("vec%0d.pm_addr", i), pm_addr, vecs[i].epm);
            check($sformatf("vec%0d.valid", i), instr_valid, vecs[i].ev);
            if (vecs[i].ev)
                check_instr($sformatf("vec%0d", i), vecs[i].eop, vecs[i].eop1,
                            vecs[i].eop2, vecs[i].elen, vecs[i].epc);
            if (i == 0)
                check_instr("reset", 8'h00, 8'h00, 8'h00, 2'd1, 8'h00);
        end

        // Two single-byte instructions back to back.
        clear_mem();
        mem[0] = 8'h12; mem[1] = 8'h00;
        step(1'b1, 1'b0, 8'h00, 1'b1);
        step(1'b0, 1'b0, 8'h00, 1'b1);
        check("single0.valid", instr_valid, 1'b1);
        check_instr("single0", 8'h12, 8'h00, 8'h00, 2'd1, 8'h00);
        step(1'b0, 1'b0, 8'h00, 1'b1);
        check("single1.valid", instr_valid, 1'b1);
        check_instr("single1", 8'h00, 8'h00, 8'h00, 2'd1, 8'h01);
        check("single1.pm_addr", pm_addr, 8'h02);

        // Jump while collecting operand 1 of a 3-byte instruction.
        clear_mem();
        mem[0] = 8'h05; mem[1] = 8'hAA; mem[2] = 8'hBB; mem[8'h21] = 8'h12;
        step(1'b1, 1'b0, 8'h00, 1'b1);
        step(1'b0, 1'b0, 8'h00, 1'b1);
        step(1'b0, 1'b1, 8'h21, 1'b1);
        check("jmpb1.valid", instr_valid, 1'b0);
        check("jmpb1.pm_addr", pm_addr, 8'h21);
        step(1'b0, 1'b0, 8'h00, 1'b1);
        check("jmpb1.next_valid", instr_valid, 1'b1);
        check_instr("jmpb1.next", 8'h12, 8'h00, 8'h00, 2'd1, 8'h21);

        // Operand fetch across the 8'hFF -> 8'h00 wrap.
        clear_mem();
        mem[8'hFE] = 8'h06; mem[8'hFF] = 8'h0C; mem[0] = 8'h03;
        step(1'b1, 1'b0, 8'h00, 1'b0);
        step(1'b0, 1'b1, 8'hFE, 1'b0);
        check("wrap.pm_addr0", pm_addr, 8'hFE);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 8'h00, 1'b0);
        check("wrap.valid", instr_valid, 1'b1);
        check_instr("wrap", 8'h06, 8'h0C, 8'h03, 2'd3, 8'hFE);
        check("wrap.pm_addr", pm_addr, 8'h01);

        // Reset wins over a simultaneous jump while holding.
        step(1'b1, 1'b1, 8'h55, 1'b0);
        check("rstjmp.valid", instr_valid, 1'b0);
        check("rstjmp.pm_addr", pm_addr, 8'h00);
        check_instr("rstjmp", 8'h00, 8'h00, 8'h00, 2'd1, 8'h00);

        // Randomized traffic against the model.
        for (int i = 0; i < 256; i++)
            mem[i] = ($urandom_range(0, 3) == 0) ? 8'($urandom())
                                                 : op_pool[$urandom_range(0, 9)];
        step(1'b1, 1'b0, 8'h00, 1'b0);
        for (int cyc = 0; cyc < 3000; cyc++) begin
            step($urandom_range(0, 199) == 0, $urandom_range(0, 29) == 0,
                 8'($urandom()), $urandom_range(0, 2) != 0);
            check($sformatf("rand%0d.pm_addr", cyc), pm_addr, m_pc);
            check($sformatf("rand%0d.valid", cyc), instr_valid, m_valid);
            if (m_valid)
                check_instr($sformatf("rand%0d", cyc), m_op, m_op1, m_op2,
                            2'(m_len), m_ipc);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
